qos_threshold_fifo: RTL
=======================

// Module: qos_threshold_fifo
// PURPOSE
//  Per-channel data FIFO in the QoS PCIe path, directly upstream of the QoS control FSM.
//  Buffers words from the ingress side and exports empty, which drives one of the FSM's
//  ten emptiesN inputs. Exports almost_empty and almost_full, computed against the
//  low/high thresholds (umbral_L/umbral_H) that the FSM hands out; these drive flow control.
// PARAMETERS
//  DATA_WIDTH  6  width of stored word
//  ADDR_WIDTH  3  log2 of depth; DEPTH = 2**ADDR_WIDTH = 8 entries
// PORTS
//  clk           in   1              clock, all logic on posedge
//  reset         in   1              synchronous, active-low
//  init          in   1              config phase; thresholds sampled while high
//  umbral_L      in   4              almost-empty threshold (from FSM umbral_out_L)
//  umbral_H      in   4              almost-full threshold (from FSM umbral_out_H)
//  push          in   1              write request
//  data_in       in   DATA_WIDTH     write data
//  pop           in   1              read request
//  data_out      out  DATA_WIDTH     read data
//  data_valid    out  1              data_out holds a popped word
//  empty         out  1              count == 0
//  full          out  1              count == DEPTH
//  almost_empty  out  1              count <= thr_L
//  almost_full   out  1              count >= thr_H
//  count         out  ADDR_WIDTH+1   current occupancy, 0..DEPTH
//  overflow_err  out  1              sticky: push attempted while full and not popping
//  underflow_err out  1              sticky: pop attempted while empty
// BEHAVIOUR
//  - Reset (reset==0 at posedge): rd/wr pointers=0, count=0, data_out=0, data_valid=0,
//    errors=0, thr_L=0, thr_H=DEPTH. Outputs: empty=1, full=0, almost_empty=1,
//    almost_full=0. Storage contents are not reset.
//  - Reset wins over every other input, including mid-transfer: in-flight words are discarded.
//  - init==1: thr_L<=umbral_L, thr_H<=umbral_H every cycle; errors are cleared.
//    Data path keeps running during init.
//  - Threshold clamp: a value > DEPTH is stored as DEPTH. thr_H==0 gives almost_full=1 always.
//  - Accept rules per cycle: wr_ok = push & (!full | pop); rd_ok = pop & !empty.
//  - Push+pop on full: both accepted; count unchanged.
//  - Push+pop on empty: push accepted; pop rejected (no bypass); underflow_err set.
//  - Rejected push: overflow_err set; memory and pointers unchanged.
//  - Pointers wrap DEPTH-1 -> 0 (natural ADDR_WIDTH rollover).
//  - count <= count + wr_ok - rd_ok.
//  - empty, full, almost_* and count are registered, so they reflect state after the
//    last edge. Flags are decoded from count, never from pointer equality.
//  - Read latency (default): on rd_ok, data_out <= mem[rd_ptr] and data_valid <= 1 at the
//    next edge. Without rd_ok, data_valid <= 0 and data_out holds its last value.
// CONFIGURATION
//  QOS_FIFO_FWFT_EN defined: first-word fall-through.
//    - data_out = mem[rd_ptr], combinational. data_valid = !empty.
//    - pop acknowledges the word currently shown; zero read latency.
//    - Accept rules, flags and errors are unchanged.
//  QOS_FIFO_FWFT_EN undefined: registered 1-cycle read as described in BEHAVIOUR.
// TESTING
//  1. Reset low 2 cycles, then high -> empty=1, count=0, almost_empty=1, almost_full=0,
//     data_valid=0, errors=0.
//  2. init=1 with umbral_L=2, umbral_H=6, then push 0x01..0x06 on consecutive cycles ->
//     almost_empty drops after 3rd push; almost_full rises after 6th; count=6.
//  3. Push 8 words, then push 0x3F with pop=0 -> full=1, overflow_err=1, count=8, 0x3F not
//     stored. Next push+pop -> count stays 8, popped word = 1st written.
//  4. From empty, pop=1 -> underflow_err=1, data_valid=0. Then push+pop in the same cycle ->
//     count=1, underflow_err stays 1 until init or reset.
//  5. Write/read 20 words at 1 per cycle (wraps pointers twice) -> data_out order matches
//     data_in, with 1-cycle latency (0 cycles under QOS_FIFO_FWFT_EN).
//  6. Fill to 5 words, pull reset low for 1 cycle -> empty=1, count=0; umbral_L=9 under
//     init -> clamps to 8, almost_empty=1 even when full.

Source files
------------

// File: rtl/qos_threshold_fifo.sv
// qos_threshold_fifo
//   Per-channel data FIFO feeding the QoS control FSM. It exports empty,
//   and almost_empty/almost_full flags compared against thresholds that are
//   latched while init is high. Thresholds are clamped to DEPTH. Registered
//   status flags are decoded from the occupancy count.
//   Optional build macro: QOS_FIFO_FWFT_EN selects first-word fall-through
//   reads. When it is undefined, reads have a registered 1-cycle latency.
module qos_threshold_fifo #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [3:0]            umbral_L,
  input  logic [3:0]            umbral_H,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = 1;
  localparam logic [CW-1:0]         CNT_ONE   = 1;
  localparam logic [CW-1:0]         CNT_DEPTH = CW'(DEPTH);

  // Thresholds above the FIFO depth are meaningless, so saturate them at DEPTH
  function automatic logic [CW-1:0] clamp_thr(input logic [3:0] u);
    if (int'(u) > DEPTH) return CNT_DEPTH;
    else return CW'(u);
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         thr_l_q, thr_l_d;
  logic [CW-1:0]         thr_h_q, thr_h_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  almost_empty_q, almost_empty_d;
  logic                  almost_full_q, almost_full_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_ok, rd_ok;

  // Accept decisions, pointer/count update, threshold capture and flag decode
  always_comb begin
    wr_ok    = push & (~full_q | pop);
    rd_ok    = pop & ~empty_q;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    thr_l_d  = thr_l_q;
    thr_h_d  = thr_h_q;

    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (init) begin
      thr_l_d     = clamp_thr(umbral_L);
      thr_h_d     = clamp_thr(umbral_H);
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      overflow_d  = overflow_q  | (push & full_q & ~pop);
      underflow_d = underflow_q | (pop & empty_q);
    end

    // Flags look at the next-state count and thresholds so they are
    // registered yet consistent with count after the same edge
    empty_d        = (count_d == '0);
    full_d         = (count_d == CNT_DEPTH);
    almost_empty_d = (count_d <= thr_l_d);
    almost_full_d  = (count_d >= thr_h_d);
  end

  // Control and status state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      thr_l_q        <= '0;
      thr_h_q        <= CNT_DEPTH;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_empty_q <= 1'b1;
      almost_full_q  <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      thr_l_q        <= thr_l_d;
      thr_h_q        <= thr_h_d;
      empty_q        <= empty_d;
      full_q         <= full_d;
      almost_empty_q <= almost_empty_d;
      almost_full_q  <= almost_full_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  // Storage write; contents are never reset, and nothing is written during reset
  always_ff @(posedge clk) begin
    if (reset && wr_ok) mem[wr_ptr_q] <= data_in;
  end

`ifdef QOS_FIFO_FWFT_EN
  // Head word is always visible; pop acknowledges what is shown
  assign data_out   = mem[rd_ptr_q];
  assign data_valid = ~empty_q;
`else
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;

  // Registered read: popped word appears one edge after the accepted pop
  always_comb begin
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    if (rd_ok) begin
      data_out_d   = mem[rd_ptr_q];
      data_valid_d = 1'b1;
    end
  end

  // Read data register; reset discards any word in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
`endif

  assign empty         = empty_q;
  assign full          = full_q;
  assign almost_empty  = almost_empty_q;
  assign almost_full   = almost_full_q;
  assign count         = count_q;
  assign overflow_err  = overflow_q;
  assign underflow_err = underflow_q;

endmodule
